// File: rtl/tail_light_seq_ctrl.sv
// Turn / hazard / brake controller for the sequential tail-light system.
// Synchronises the driver switches, runs the mode FSM and the animation-step
// prescaler, and decodes the 3-lamp pattern for each side plus the side
// enables that gate the downstream display-mux animation counters.
module tail_light_seq_ctrl #(
   parameter int TICK_DIV    = 25_000_000,  // clk cycles per animation step, >= 2
   parameter int SYNC_STAGES = 2            // synchroniser depth, >= 2
) (
   input  logic       clk,
   input  logic       reset,        // synchronous, active-low
   input  logic       left_sw,
   input  logic       right_sw,
   input  logic       hazard_sw,
   input  logic       brake_sw,
   output logic [2:0] left_lamps,   // bit0 = innermost lamp
   output logic [2:0] right_lamps,  // bit0 = innermost lamp
   output logic       en_left,
   output logic       en_right,
   output logic       step_tick,
   output logic [1:0] phase
);

   localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   // Encoding chosen so bit0 means "left animates" and bit1 means "right
   // animates"; the side enables then come straight off flop outputs.
   typedef enum logic [1:0] {
      MODE_IDLE   = 2'b00,
      MODE_LEFT   = 2'b01,
      MODE_RIGHT  = 2'b10,
      MODE_HAZARD = 2'b11
   } mode_t;

   // Switch vector layout: {brake, hazard, right, left}
   logic [SYNC_STAGES-1:0][3:0] sync_q;
   logic                        left_s, right_s, hazard_s, brake_s;

   mode_t            mode_q, mode_d, mode_req;
   logic [1:0]       phase_q, phase_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             tick_q, tick_d;
   logic [2:0]       turn_pat, brake_pat;

   // Shift each raw switch through its synchroniser chain.
   // NOTE: clocked state is always written with <= so every flop samples the
   // pre-edge value of its neighbour; a blocking = here would collapse the chain.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], {brake_sw, hazard_sw, right_sw, left_sw}};
      end
   end

   assign left_s   = sync_q[SYNC_STAGES-1][0];
   assign right_s  = sync_q[SYNC_STAGES-1][1];
   assign hazard_s = sync_q[SYNC_STAGES-1][2];
   assign brake_s  = sync_q[SYNC_STAGES-1][3];

   // Prioritised mode request from the synchronised switches.
   // NOTE: every always_comb output gets a default first, so no path through
   // the if/case chain can leave it unassigned and infer a latch.
   always_comb begin
      mode_req = MODE_IDLE;
      if (hazard_s || (left_s && right_s)) begin
         mode_req = MODE_HAZARD;
      end else if (left_s) begin
         mode_req = MODE_LEFT;
      end else if (right_s) begin
         mode_req = MODE_RIGHT;
      end
   end

   // Next-state logic: a mode change restarts the animation from phase 0 and
   // overrides a step that would have landed on the same edge.
   always_comb begin
      mode_d  = mode_q;
      phase_d = phase_q;
      count_d = count_q;
      tick_d  = 1'b0;
      if (mode_req != mode_q) begin
         mode_d  = mode_req;
         phase_d = 2'd0;
         count_d = '0;
      end else if (mode_q != MODE_IDLE) begin
         if (count_q == CNT_LAST) begin
            count_d = '0;
            tick_d  = 1'b1;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
         if (tick_q) begin
            phase_d = (mode_q == MODE_HAZARD) ? {1'b0, ~phase_q[0]} : phase_q + 2'd1;
         end
      end
   end

   // Mode, phase, prescaler and step-pulse registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mode_q  <= MODE_IDLE;
         phase_q <= 2'd0;
         count_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         mode_q  <= mode_d;
         phase_q <= phase_d;
         count_q <= count_d;
         tick_q  <= tick_d;
      end
   end

   // Lamp patterns decoded from registered mode, phase and synchronised brake.
   always_comb begin
      brake_pat = brake_s ? 3'b111 : 3'b000;
      case (phase_q)
         2'd0:    turn_pat = 3'b000;
         2'd1:    turn_pat = 3'b001;
         2'd2:    turn_pat = 3'b011;
         default: turn_pat = 3'b111;
      endcase
      left_lamps  = brake_pat;
      right_lamps = brake_pat;
      case (mode_q)
         MODE_LEFT:   left_lamps  = turn_pat;
         MODE_RIGHT:  right_lamps = turn_pat;
         MODE_HAZARD: begin
            left_lamps  = phase_q[0] ? 3'b111 : 3'b000;
            right_lamps = phase_q[0] ? 3'b111 : 3'b000;
         end
         default: ;
      endcase
   end

   assign en_left   = mode_q[0];
   assign en_right  = mode_q[1];
   assign step_tick = tick_q;
   assign phase     = phase_q;

endmodule

// File: tb/tb_tail_light_seq_ctrl.sv
// Self-checking bench for tail_light_seq_ctrl: a behavioural model predicts
// every cycle's outputs into a scoreboard queue, a monitor compares them.
module tb_tail_light_seq_ctrl;

   localparam int TICK_DIV    = 4;
   localparam int SYNC_STAGES = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       left_sw = 1'b0, right_sw = 1'b0, hazard_sw = 1'b0, brake_sw = 1'b0;
   logic [2:0] left_lamps, right_lamps;
   logic       en_left, en_right, step_tick;
   logic [1:0] phase;

   tail_light_seq_ctrl #(
      .TICK_DIV   (TICK_DIV),
      .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .left_sw    (left_sw),
      .right_sw   (right_sw),
      .hazard_sw  (hazard_sw),
      .brake_sw   (brake_sw),
      .left_lamps (left_lamps),
      .right_lamps(right_lamps),
      .en_left    (en_left),
      .en_right   (en_right),
      .step_tick  (step_tick),
      .phase      (phase)
   );

   always #5 clk = ~clk;

   // Expected output bundle: {left, right, en_left, en_right, step_tick, phase}
   typedef logic [10:0] obs_t;
   typedef enum int {M_IDLE, M_LEFT, M_RIGHT, M_HAZARD} m_e;

   int   checks   = 0;
   int   failures = 0;
   int   pushed   = 0;
   int   popped   = 0;
   obs_t sb[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
      end
   endtask

   // Reference model: synchronised switches are simply the samples from
   // SYNC_STAGES edges ago; phase and step pulse follow from the number of
   // cycles spent in the current mode.
   logic [3:0] m_sync[$];
   m_e         m_mode = M_IDLE;
   int         m_cyc  = 0;

   function automatic m_e request_of(input logic [3:0] s);
      if (s[2] || (s[0] && s[1])) return M_HAZARD;
      if (s[0]) return M_LEFT;
      if (s[1]) return M_RIGHT;
      return M_IDLE;
   endfunction

   always @(posedge clk) begin : model
      m_e         req;
      int         ph;
      logic       tk, brk;
      logic [2:0] turn, bp, l, r;
      if (!reset) begin
         m_sync = {};
         for (int i = 0; i < SYNC_STAGES; i++) m_sync.push_back(4'h0);
         m_mode = M_IDLE;
         m_cyc  = 0;
      end else begin
         req = request_of(m_sync[0]);
         if (req != m_mode) begin
            m_mode = req;
            m_cyc  = 0;
         end else if (m_mode != M_IDLE) begin
            m_cyc++;
         end
         void'(m_sync.pop_front());
         m_sync.push_back({brake_sw, hazard_sw, right_sw, left_sw});
      end
      ph   = (m_mode == M_IDLE || m_cyc == 0) ? 0
           : ((m_cyc - 1) / TICK_DIV) % ((m_mode == M_HAZARD) ? 2 : 4);
      tk   = (m_mode != M_IDLE) && (m_cyc > 0) && (m_cyc % TICK_DIV == 0);
      brk  = m_sync[0][3];
      turn = 3'((1 << ph) - 1);
      bp   = brk ? 3'b111 : 3'b000;
      l    = bp;
      r    = bp;
      if (m_mode == M_LEFT)  l = turn;
      if (m_mode == M_RIGHT) r = turn;
      if (m_mode == M_HAZARD) begin
         l = (ph == 1) ? 3'b111 : 3'b000;
         r = l;
      end
      sb.push_back({l, r, m_mode == M_LEFT || m_mode == M_HAZARD,
                    m_mode == M_RIGHT || m_mode == M_HAZARD, tk, 2'(ph)});
      pushed++;
   end

   // Monitor: compare the DUT against the oldest prediction, away from posedge.
   always @(negedge clk) begin
      obs_t want;
      if (sb.size() > 0) begin
         want = sb.pop_front();
         popped++;
         check("outputs{L,R,enL,enR,tick,ph}",
               32'({left_lamps, right_lamps, en_left, en_right, step_tick, phase}),
               32'(want));
      end
   end

   task automatic drive(input logic l, input logic r, input logic h, input logic b,
                        input int cycles);
      left_sw   = l;
      right_sw  = r;
      hazard_sw = h;
      brake_sw  = b;
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with every switch asserted, then HAZARD loads on cycle 3.
      @(negedge clk);
      reset = 1'b0;
      drive(1, 1, 1, 1, 3);
      reset = 1'b1;
      drive(1, 1, 1, 1, 8);
      // Left turn full sequence.
      drive(1, 0, 0, 0, 22);
      // Right turn with brake, then brake released mid-sequence.
      drive(0, 1, 0, 1, 10);
      drive(0, 1, 0, 0, 10);
      // Both turn switches -> hazard, brake ignored.
      drive(1, 1, 0, 1, 18);
      // Enter LEFT, then drop it so the mode change meets a step pulse.
      left_sw = 1'b1; right_sw = 1'b0; hazard_sw = 1'b0; brake_sw = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 0, 12);
      // Reset while LEFT is in phase 2.
      drive(1, 0, 0, 0, 14);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      drive(1, 0, 0, 0, 6);
      // Randomised traffic with occasional reset pulses.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 29) == 0) begin
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
         end
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
               $urandom_range(1, 12));
      end
      drive(0, 0, 0, 0, 4);
      #1;
      check("scoreboard_drained", 32'(popped), 32'(pushed));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
